// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit.
//
// A radix-2 shift-add multiplier and a restoring divider share one
// 2*DATA_WIDTH accumulator and retire one bit per cycle. Division by zero and
// signed overflow bypass the iteration and complete in one cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   Start      request, sampled only while idle
//   Flush      synchronous abort of the current or requested operation
//   SrcA       multiplicand / dividend
//   SrcB       multiplier / divisor
//   Operation  funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   Busy       high while an operation is in flight (CALC and DONE)
//   Done       one-cycle pulse, ALUResult valid
//   ALUResult  result, held until the next Done
module muldiv_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Start,
    input  logic                     Flush,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     Busy,
    output logic                     Done,
    output logic [DATA_WIDTH-1:0]    ALUResult
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [OPCODE_LENGTH-1:0] OP_MUL    = OPCODE_LENGTH'(0);
    localparam logic [OPCODE_LENGTH-1:0] OP_MULH   = OPCODE_LENGTH'(1);
    localparam logic [OPCODE_LENGTH-1:0] OP_MULHSU = OPCODE_LENGTH'(2);
    localparam logic [OPCODE_LENGTH-1:0] OP_DIV    = OPCODE_LENGTH'(4);
    localparam logic [OPCODE_LENGTH-1:0] OP_DIVU   = OPCODE_LENGTH'(5);
    localparam logic [OPCODE_LENGTH-1:0] OP_REM    = OPCODE_LENGTH'(6);
    localparam logic [OPCODE_LENGTH-1:0] OP_REMU   = OPCODE_LENGTH'(7);

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            count_q, count_d;
    logic [2*W-1:0]           acc_q, acc_d;
    logic [W-1:0]             mag_a_q, mag_a_d;
    logic [W-1:0]             mag_b_q, mag_b_d;
    logic [OPCODE_LENGTH-1:0] op_q, op_d;
    logic                     neg_q, neg_d;     // sign of product / quotient
    logic                     sa_q, sa_d;       // sign of remainder
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [W-1:0]             result_q, result_d;

    // Decode of the requested operation (used only at accept)
    logic           in_is_div, in_is_rem, in_a_signed, in_b_signed;
    logic           in_sa, in_sb, in_div_zero, in_overflow;
    logic [W-1:0]   in_mag_a, in_mag_b, fast_res;

    // One iteration of the shared datapath
    logic           q_is_div, q_is_rem;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_step;
    logic [W:0]     rem_sh, div_diff;
    logic [2*W-1:0] div_step;
    logic [2*W-1:0] step;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot_fix, rem_fix, final_res;

    always_comb begin
        in_is_div   = Operation inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        in_is_rem   = (Operation == OP_REM) || (Operation == OP_REMU);
        in_a_signed = Operation inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        in_b_signed = Operation inside {OP_MULH, OP_DIV, OP_REM};
        in_sa       = in_a_signed & SrcA[W-1];
        in_sb       = in_b_signed & SrcB[W-1];
        // The most negative value negates to itself, which is the correct
        // unsigned magnitude 2^(W-1).
        in_mag_a    = in_sa ? (~SrcA + 1'b1) : SrcA;
        in_mag_b    = in_sb ? (~SrcB + 1'b1) : SrcB;
        in_div_zero = in_is_div && (SrcB == '0);
        in_overflow = ((Operation == OP_DIV) || (Operation == OP_REM))
                      && (SrcA == MOST_NEG) && (SrcB == '1);
        if (in_div_zero)
            fast_res = in_is_rem ? SrcA : '1;
        else
            fast_res = in_is_rem ? '0 : SrcA;
    end

    always_comb begin
        q_is_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        q_is_rem = (op_q == OP_REM) || (op_q == OP_REMU);

        // Multiply: add multiplicand into the upper half when the multiplier
        // LSB is set, then shift right; the carry becomes the new MSB.
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? mag_a_q : '0)};
        mul_step = {mul_sum, acc_q[W-1:1]};

        // Divide: shift {rem, quot} left, trial-subtract the divisor.
        rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff = rem_sh - {1'b0, mag_b_q};
        if (div_diff[W])
            div_step = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
        else
            div_step = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};

        step = q_is_div ? div_step : mul_step;

        // Sign correction on the final iteration's output
        prod_fix = neg_q ? (~step + 1'b1) : step;
        quot_fix = neg_q ? (~step[W-1:0] + 1'b1) : step[W-1:0];
        rem_fix  = sa_q ? (~step[2*W-1:W] + 1'b1) : step[2*W-1:W];
        if (q_is_div)
            final_res = q_is_rem ? rem_fix : quot_fix;
        else
            final_res = (op_q == OP_MUL) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        op_d     = op_q;
        neg_d    = neg_q;
        sa_d     = sa_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    mag_a_d = in_mag_a;
                    mag_b_d = in_mag_b;
                    op_d    = Operation;
                    neg_d   = in_sa ^ in_sb;
                    sa_d    = in_sa;
                    // Dividend or multiplier starts in the low half
                    acc_d   = {{W{1'b0}}, (in_is_div ? in_mag_a : in_mag_b)};
                    if (in_div_zero || in_overflow) begin
                        state_d  = S_DONE;
                        count_d  = '0;
                        result_d = fast_res;
                        done_d   = 1'b1;
                    end else begin
                        state_d = S_CALC;
                        count_d = CW'(W);
                    end
                end
            end
            S_CALC: begin
                acc_d   = step;
                count_d = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    state_d  = S_DONE;
                    result_d = final_res;
                    done_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including an accept in the same cycle;
        // the captured operands are don't-care once idle.
        if (Flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
            done_d   = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            sa_q     <= sa_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign ALUResult = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit, parametrised in data width, that extends the single-cycle ALU with the eight M-extension operations. It sits in the EX stage beside the ALU. The pipeline stalls on `Busy` while an operation runs, and `Flush` cancels an in-flight operation on a branch redirect. Results come from a radix-2 shift-add multiplier and a restoring divider that share one datapath: one bit per cycle, with a fast path for the special division cases.

## Interface
- `DATA_WIDTH`, 32: operand and result width; must be ≥ 4 and even.
- `OPCODE_LENGTH`, 3: width of `Operation`; carries funct3 directly.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `Start`  in  1  request; sampled only in IDLE.
- `Flush`  in  1  synchronous abort of the current or requested operation.
- `SrcA`  in  DATA_WIDTH  multiplicand / dividend; captured on accept.
- `SrcB`  in  DATA_WIDTH  multiplier / divisor; captured on accept.
- `Operation`  in  OPCODE_LENGTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `Busy`  out  1  high in CALC and DONE.
- `Done`  out  1  one-cycle pulse; `Result` is valid this cycle.
- `ALUResult`  out  DATA_WIDTH  result; holds its value until the next `Done`.

## Operation
- **States:** IDLE, CALC, DONE.
- **Accept:** in IDLE, `Start` && !`Flush` captures `SrcA`, `SrcB` and `Operation`.
  - Normal case: go to CALC with counter = DATA_WIDTH.
  - Fast path: go straight to DONE.
- **Signedness:** A is signed for MULH, MULHSU, DIV and REM. B is signed for MULH, DIV and REM. MUL uses the low half of the product and is sign-agnostic.
- **Datapath:** operands are converted to magnitudes on accept. The core runs on unsigned DATA_WIDTH-bit magnitudes.
  - Product sign = sA ^ sB.
  - Quotient sign = sA ^ sB.
  - Remainder sign = sA.
  - Two's-complement correction is applied at the CALC→DONE transition.
- **Multiply:** each CALC cycle adds the multiplicand into the upper half when the current multiplier LSB is 1, then shifts the 2·DATA_WIDTH accumulator right by 1.
  - MUL returns the low half.
  - MULH, MULHSU and MULHU return the high half.
- **Divide:** each CALC cycle shifts {rem, quot} left by 1 and trial-subtracts the divisor.
  - If the trial result is non-negative, the remainder is replaced and quotient bit = 1.
  - DIV and DIVU return the quotient; REM and REMU return the remainder.
- **CALC:** one iteration per cycle, counter decrements. The cycle with counter == 1 moves to DONE.
- **DONE:** `Done` = 1 and `ALUResult` is updated. Next state is IDLE unconditionally. A `Start` in DONE is ignored, so the requester must hold it.
- **Fast path:** decided at accept, with no CALC cycles.
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = SrcA.
  - Signed overflow (DIV/REM with SrcA = 1 followed by zeros, SrcB = all ones): quotient = SrcA, remainder = 0.
- **Start while Busy:** ignored; the operands are not captured.
- **Flush:** in any state, the next state is IDLE, no `Done`, and `ALUResult` is unchanged. `Flush` with `Start` in IDLE: flush wins and nothing is accepted.
- **Reset (including mid-operation):** state = IDLE, counter = 0, `Busy` = 0, `Done` = 0, `ALUResult` = 0, captured operands = 0.

## Timing
- Accept edge = edge 0.
- **Normal latency:** CALC occupies DATA_WIDTH cycles.
  - `Done` is high in the cycle after edge DATA_WIDTH+... specifically, `Done` asserts DATA_WIDTH+1 cycles after the accept cycle (cycle 33 for 32 bits).
  - `Busy` is high for DATA_WIDTH+1 cycles.
- **Fast-path latency:** `Done` is high in cycle 1; `Busy` is high for 1 cycle.
- **Back-to-back issue:** the earliest next accept is the cycle after DONE, i.e. a throughput of 1 op per DATA_WIDTH+2 cycles.
- **Output registering:** `Busy`, `Done` and `ALUResult` are registered outputs with no combinational path from the inputs.

## Test plan
- **MUL:** MUL 7 × 0xFFFFFFFD → `ALUResult` 0xFFFFFFEB; `Done` exactly at cycle 33; `Busy` high cycles 1–33.
- **High-half products:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Signed division:** DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; REMU 100 / 7 → 2.
- **Special cases:**
  - DIVU 5 / 0 → 0xFFFFFFFF with `Done` at cycle 1.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
- **Abort:**
  - `Flush` at cycle 10 of a MUL → IDLE next cycle, no `Done`, `ALUResult` keeps its prior value.
  - `reset` at cycle 10 → `ALUResult` = 0, `Busy` = 0.
- **Ignored starts:** `Start` with new operands at cycles 5 and 33 of a DIVU 100/7 → ignored; result 14. A new accept at cycle 34 succeeds.
